mmio_port_responder: RTL

- Memory-mapped I/O responder on the processor's MEM-stage data bus. The pipeline is the initiator; this block answers its loads and stores.
- Drives the 32-bit output port from a writable register.
- Samples the 8-bit input port through a synchronizer and a programmable debouncer.
- Records input changes in a sticky flag and a saturating counter that software can poll.

---
 rtl/mmio_port_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mmio_port_responder.sv
// MMIO responder on the MEM-stage data bus: a 32-bit output port register, plus a
// synchronized and debounced input port with a sticky change flag and a saturating change counter.
module mmio_port_responder #(
   parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0000,
   parameter logic [15:0] DEBOUNCE_RESET = 16'd4,
   parameter int          PORT_IN_WIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     MemWrite,
   input  logic                     MemRead,
   input  logic [31:0]              Address,
   input  logic [31:0]              WriteData,
   output logic [31:0]              ReadData,
   output logic                     Hit,
   input  logic [PORT_IN_WIDTH-1:0] PortIn,
   output logic [31:0]              PortOut,
   output logic                     PortOutStrobe
);

   typedef enum logic [2:0] {
      REG_PORT_OUT     = 3'd0,
      REG_PORT_IN      = 3'd1,
      REG_STATUS       = 3'd2,
      REG_CHANGE_COUNT = 3'd3,
      REG_DEBOUNCE     = 3'd4
   } reg_sel_e;

   logic                     hit;
   logic [2:0]               sel;
   logic                     wr_en;
   logic                     rd_en;
   logic                     accept;
   logic [31:0]              read_data;
   logic                     unused_addr_bits;

   logic [PORT_IN_WIDTH-1:0] sync1_q, sync1_d;
   logic [PORT_IN_WIDTH-1:0] sync2_q, sync2_d;
   logic [PORT_IN_WIDTH-1:0] cand_q, cand_d;
   logic [PORT_IN_WIDTH-1:0] accepted_q, accepted_d;
   logic [15:0]              stable_cnt_q, stable_cnt_d;
   logic                     in_changed_q, in_changed_d;
   logic [15:0]              change_count_q, change_count_d;
   logic [15:0]              debounce_q, debounce_d;
   logic [31:0]              port_out_q, port_out_d;
   logic                     port_out_strobe_q, port_out_strobe_d;

   // Word access only: the byte lane bits take no part in decode.
   assign unused_addr_bits = ^Address[1:0];

   always_comb begin
      hit   = (Address[31:5] == BASE_ADDR[31:5]);
      sel   = Address[4:2];
      wr_en = hit && MemWrite;
      rd_en = hit && MemRead;
   end

   // Read mux works from pre-edge state, so a combined load/store sees the old value.
   always_comb begin
      read_data = '0;
      if (hit) begin
         case (sel)
            REG_PORT_OUT:     read_data = port_out_q;
            REG_PORT_IN:      read_data = 32'(accepted_q);
            REG_STATUS:       read_data = {31'd0, in_changed_q};
            REG_CHANGE_COUNT: read_data = {16'd0, change_count_q};
            REG_DEBOUNCE:     read_data = {16'd0, debounce_q};
            default:          read_data = '0;
         endcase
      end
   end

   // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      sync1_d      = PortIn;
      sync2_d      = sync1_q;
      cand_d       = cand_q;
      accepted_d   = accepted_q;
      stable_cnt_d = stable_cnt_q;
      accept       = 1'b0;
      if (sync2_q != cand_q) begin
         cand_d       = sync2_q;
         stable_cnt_d = '0;
      end else if (cand_q != accepted_q) begin
         if (stable_cnt_q == debounce_q) begin
            accept       = 1'b1;
            accepted_d   = cand_q;
            stable_cnt_d = '0;
         end else begin
            stable_cnt_d = stable_cnt_q + 16'd1;
         end
      end else begin
         stable_cnt_d = '0;
      end
   end

   // Bus side effects first; an accept on the same edge then takes priority.
   always_comb begin
      port_out_d        = port_out_q;
      port_out_strobe_d = 1'b0;
      debounce_d        = debounce_q;
      in_changed_d      = in_changed_q;
      change_count_d    = change_count_q;
      if (wr_en) begin
         case (sel)
            REG_PORT_OUT: begin
               port_out_d        = WriteData;
               port_out_strobe_d = 1'b1;
            end
            REG_CHANGE_COUNT: change_count_d = '0;
            REG_DEBOUNCE:     debounce_d     = WriteData[15:0];
            default:          ;
         endcase
      end
      if (rd_en && (sel == REG_PORT_IN)) begin
         in_changed_d = 1'b0;
      end
      if (accept) begin
         in_changed_d = 1'b1;
         if (change_count_d != 16'hFFFF) begin
            change_count_d = change_count_d + 16'd1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q           <= '0;
         sync2_q           <= '0;
         cand_q            <= '0;
         accepted_q        <= '0;
         stable_cnt_q      <= '0;
         in_changed_q      <= 1'b0;
         change_count_q    <= '0;
         debounce_q        <= DEBOUNCE_RESET;
         port_out_q        <= '0;
         port_out_strobe_q <= 1'b0;
      end else begin
         sync1_q           <= sync1_d;
         sync2_q           <= sync2_d;
         cand_q            <= cand_d;
         accepted_q        <= accepted_d;
         stable_cnt_q      <= stable_cnt_d;
         in_changed_q      <= in_changed_d;
         change_count_q    <= change_count_d;
         debounce_q        <= debounce_d;
         port_out_q        <= port_out_d;
         port_out_strobe_q <= port_out_strobe_d;
      end
   end

   assign Hit           = hit;
   assign ReadData      = read_data;
   assign PortOut       = port_out_q;
   assign PortOutStrobe = port_out_strobe_q;

endmodule
